uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter WAIT, default 8, clocks per UART bit; SHALL be >= 2.
REQ-002 Parameter N_REQ, default 2, number of requesters; SHALL be fixed at 2 for this revision.
REQ-003 Port clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  [N_REQ-1:0]  requester i has a byte pending.
REQ-006 Port req_data  input  [N_REQ-1:0][7:0]  byte offered by requester i.
REQ-007 Port req_ready  output  [N_REQ-1:0]  one-cycle accept strobe to requester i.
REQ-008 Port uart_tx  output  1  serial line; idle high.
REQ-009 Port busy  output  1  frame in progress.
REQ-010 Port grant_id  output  1  index of requester owning the current or last frame.

Function
REQ-011 States SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE: if no valid, stay; else grant one requester, assert its req_ready combinationally for that cycle, latch its data, go to START.
REQ-013 Grant SHALL be round-robin: the requester not granted last wins a tie; a single valid requester always wins.
REQ-014 req_ready SHALL be asserted only in IDLE, for at most one requester, for exactly one cycle per frame.
REQ-015 Requester SHALL hold valid and data stable until ready; data SHALL be sampled only on the ready cycle.
REQ-016 START: uart_tx = 0 for WAIT clocks, then DATA.
REQ-017 DATA: 8 bits LSB first, each held WAIT clocks; bit index 3 bits, wraps 7->0 on exit to STOP.
REQ-018 STOP: uart_tx = 1 for WAIT clocks, then IDLE.
REQ-019 Frame = 10*WAIT clocks from first START cycle to IDLE entry; back-to-back frames separated by exactly one IDLE cycle.
REQ-020 uart_tx SHALL be registered (no combinational path from req_*).
REQ-021 busy = 1 in START/DATA/STOP, 0 in IDLE.
REQ-022 Bit-period counter width $clog2(WAIT); counts 0..WAIT-1, reloads on every bit boundary.
REQ-023 A valid dropped before its ready SHALL cause no transfer and no state change.
REQ-024 req_valid changes during a frame SHALL be ignored until the next IDLE cycle.

Reset
REQ-025 Reset assertion SHALL immediately force: state IDLE, uart_tx 1, busy 0, req_ready 0, grant_id 0, counters 0, round-robin pointer favouring requester 0.
REQ-026 Reset mid-frame SHALL abandon the frame without retransmission; the accepted byte is lost.
REQ-027 First arbitration SHALL occur on the first rising edge with reset low.

Structure
REQ-028 Shared package lib_cpu SHALL hold the state enum uart_tx_state_t and constant UART_DATA_W = 8.
REQ-029 Serializer (START/DATA/STOP sequencing, counters, uart_tx register) SHALL be sub-module uart_tx_serializer with load/byte inputs and busy output; arbitration and handshake stay in uart_tx_sched.
REQ-030 uart_tx_sched SHALL be instantiable inside mother_board in place of a direct CPU-to-UART TX path, sharing WAIT.

Verification (WAIT=8, 10 ns clock)
REQ-031 req0 sends 0x0F alone -> one ready pulse to req0; uart_tx low 80 ns, bits 1,1,1,1,0,0,0,0 at 80 ns each, high 80 ns; busy high 800 ns.
REQ-032 Both valid in first cycle after reset, req0 0x41, req1 0x42 -> 0x41 framed first, grant_id 0, then one idle cycle, then 0x42 with grant_id 1.
REQ-033 Both valid held continuously for 4 frames -> grant order 0,1,0,1; each ready pulse exactly one cycle.
REQ-034 req1 alone sends 0x55 three times -> granted every time; frames spaced 81 clocks apart.
REQ-035 Reset pulsed during DATA bit 3 -> uart_tx 1 and busy 0 without waiting for clk; next request after release produces a full, correct frame.
REQ-036 req0 valid pulsed one cycle during a frame, then dropped -> no ready to req0, no extra frame.

Source files
------------

// File: rtl/lib_cpu.sv
// Shared definitions for the UART transmit path: frame state encoding,
// data width and the two-requester round-robin pick.
package lib_cpu;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  // Winner index for two requesters. On a tie, the one not granted last wins.
  // A lone requester always wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    if (valid == 2'b11) begin
      return ~last;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, 8 data bits LSB first, stop bit, each
// held for WAIT clocks. The line and busy flag are driven straight from flops.
module uart_tx_serializer
  import lib_cpu::*;
#(
  parameter int WAIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [UART_DATA_W-1:0] data,
  output logic                   tx,
  output logic                   busy
);

  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);

  uart_tx_state_t         state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // Frame sequencer: bit-period counter, bit index and the registered line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (load) begin
            shreg <= data;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx <= shreg[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin front end for a UART transmitter. Accepts one
// byte per frame with a single-cycle ready strobe while the line is idle.
module uart_tx_sched
  import lib_cpu::*;
#(
  parameter int WAIT  = 8,
  parameter int N_REQ = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][UART_DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]                    req_ready,
  output logic                                uart_tx,
  output logic                                busy,
  output logic                                grant_id
);

  logic                   last_grant;
  logic                   winner;
  logic                   accept;
  logic [UART_DATA_W-1:0] load_data;

  // Arbitration and handshake; ready is suppressed while reset is held.
  always_comb begin
    winner    = rr_pick(req_valid[1:0], last_grant);
    accept    = (|req_valid) && !busy && !reset;
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
    load_data = req_data[winner];
  end

  // Round-robin history; after reset requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      grant_id   <= winner;
      last_grant <= winner;
    end
  end

  uart_tx_serializer #(
    .WAIT(WAIT)
  ) u_ser (
    .clk  (clk),
    .reset(reset),
    .load (accept),
    .data (load_data),
    .tx   (uart_tx),
    .busy (busy)
  );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with WAIT=8 and a 10 ns clock.
module tb_uart_tx_sched;

  localparam int WAIT = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0][7:0] req_data = '0;
  logic [1:0]      req_ready;
  logic            uart_tx;
  logic            busy;
  logic            grant_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_sched #(
    .WAIT (WAIT),
    .N_REQ(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Rising-edge count used to measure frame spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Samples one 80-cycle frame starting at the negedge of its first START
  // cycle; optionally pulses req_valid[0] for one cycle at pulse_at.
  task automatic capture_frame(input int pulse_at, output logic [7:0] got,
                               output logic shape_ok, output int busy_low,
                               output int ready_cnt);
    logic [79:0] line;
    logic        want;
    line      = '0;
    busy_low  = 0;
    ready_cnt = 0;
    shape_ok  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (pulse_at >= 0 && i == pulse_at) req_valid[0] = 1'b1;
      if (pulse_at >= 0 && i == pulse_at + 1) req_valid[0] = 1'b0;
      #1;
      line[i] = uart_tx;
      if (busy !== 1'b1) busy_low++;
      if (req_ready !== 2'b00) ready_cnt++;
      @(negedge clk);
    end
    for (int b = 0; b < 8; b++) got[b] = line[8 * b + 12];
    for (int i = 0; i < 80; i++) begin
      if (i < 8) want = 1'b0;
      else if (i >= 72) want = 1'b1;
      else want = got[(i - 8) / 8];
      if (line[i] !== want) shape_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    #2 reset  = 1'b1;
    req_valid = 2'b11;
    req_data[0] = 8'h41;
    req_data[1] = 8'h42;
    repeat (3) @(negedge clk);
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx got=%b exp=1", uart_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=00", req_ready); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_grant got=%b exp=0", grant_id); end
  endtask

  task automatic test_tie();
    logic [7:0] got;
    logic       ok;
    int         bl, rc;
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL tie_ready0 got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b10;
    capture_frame(-1, got, ok, bl, rc);
    total++; if (got !== 8'h41) begin bad++; $display("[TB] FAIL tie_byte0 got=%h exp=41", got); end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL tie_shape0 got=%b exp=1", ok); end
    total++; if (bl !== 0) begin bad++; $display("[TB] FAIL tie_busy0 low_cycles=%0d exp=0", bl); end
    total++; if (rc !== 0) begin bad++; $display("[TB] FAIL tie_ready_in_frame got=%0d exp=0", rc); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("[TB] FAIL tie_grant0 got=%b exp=0", grant_id); end
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL tie_ready1 got=%b exp=10", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL tie_idle_busy got=%b exp=0", busy); end
    @(negedge clk);
    req_valid = 2'b00;
    capture_frame(-1, got, ok, bl, rc);
    total++; if (got !== 8'h42) begin bad++; $display("[TB] FAIL tie_byte1 got=%h exp=42", got); end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL tie_shape1 got=%b exp=1", ok); end
    total++; if (grant_id !== 1'b1) begin bad++; $display("[TB] FAIL tie_grant1 got=%b exp=1", grant_id); end
  endtask

  task automatic test_single();
    logic [7:0] got;
    logic       ok;
    int         bl, rc;
    req_data[0] = 8'h0F;
    req_valid   = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_ready got=%b exp=01", req_ready); end
    @(negedge clk);
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL single_ready_width got=%b exp=00", req_ready); end
    total++; if (uart_tx !== 1'b0) begin bad++; $display("[TB] FAIL single_start got=%b exp=0", uart_tx); end
    req_valid = 2'b00;
    capture_frame(-1, got, ok, bl, rc);
    total++; if (got !== 8'h0F) begin bad++; $display("[TB] FAIL single_byte got=%h exp=0f", got); end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL single_shape got=%b exp=1", ok); end
    total++; if (bl !== 0) begin bad++; $display("[TB] FAIL single_busy low_cycles=%0d exp=0", bl); end
    total++; if (rc !== 0) begin bad++; $display("[TB] FAIL single_extra_ready got=%0d exp=0", rc); end
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_end_busy got=%b exp=0", busy); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL single_end_tx got=%b exp=1", uart_tx); end
  endtask

  task automatic test_req1_repeat();
    logic [7:0] got;
    logic       ok;
    int         bl, rc;
    int         t[3];
    req_data[1] = 8'h55;
    req_valid   = 2'b10;
    for (int f = 0; f < 3; f++) begin
      #1;
      total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL rep_ready%0d got=%b exp=10", f, req_ready); end
      t[f] = cyc;
      @(negedge clk);
      if (f == 2) req_valid = 2'b00;
      capture_frame(-1, got, ok, bl, rc);
      total++; if (got !== 8'h55) begin bad++; $display("[TB] FAIL rep_byte%0d got=%h exp=55", f, got); end
      total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rep_shape%0d got=%b exp=1", f, ok); end
      total++; if (grant_id !== 1'b1) begin bad++; $display("[TB] FAIL rep_grant%0d got=%b exp=1", f, grant_id); end
    end
    total++; if (t[1] - t[0] !== 81) begin bad++; $display("[TB] FAIL rep_gap01 got=%0d exp=81", t[1] - t[0]); end
    total++; if (t[2] - t[1] !== 81) begin bad++; $display("[TB] FAIL rep_gap12 got=%0d exp=81", t[2] - t[1]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    logic       ok;
    int         bl, rc;
    logic       exp_id;
    logic [7:0] exp_byte;
    req_data[0] = 8'hA0;
    req_data[1] = 8'hB1;
    req_valid   = 2'b11;
    for (int f = 0; f < 4; f++) begin
      exp_id   = f[0];
      exp_byte = exp_id ? 8'hB1 : 8'hA0;
      #1;
      total++; if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL b2b_ready%0d got=%b exp_id=%0d", f, req_ready, exp_id); end
      @(negedge clk);
      if (f == 3) req_valid = 2'b00;
      capture_frame(-1, got, ok, bl, rc);
      total++; if (got !== exp_byte) begin bad++; $display("[TB] FAIL b2b_byte%0d got=%h exp=%h", f, got, exp_byte); end
      total++; if (rc !== 0) begin bad++; $display("[TB] FAIL b2b_ready_width%0d got=%0d exp=0", f, rc); end
      total++; if (grant_id !== exp_id) begin bad++; $display("[TB] FAIL b2b_grant%0d got=%b exp=%b", f, grant_id, exp_id); end
    end
  endtask

  task automatic test_drop();
    logic [7:0] got;
    logic       ok;
    int         bl, rc;
    int         busy_cnt;
    req_data[1] = 8'h24;
    req_valid   = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL drop_ready1 got=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid   = 2'b00;
    req_data[0] = 8'h99;
    capture_frame(20, got, ok, bl, rc);
    total++; if (got !== 8'h24) begin bad++; $display("[TB] FAIL drop_byte got=%h exp=24", got); end
    total++; if (rc !== 0) begin bad++; $display("[TB] FAIL drop_ready_in_frame got=%0d exp=0", rc); end
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL drop_ready_after got=%b exp=00", req_ready); end
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_cnt++;
    end
    total++; if (busy_cnt !== 0) begin bad++; $display("[TB] FAIL drop_extra_frame busy_cycles=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    logic       ok;
    int         bl, rc;
    int         busy_cnt;
    req_data[0] = 8'hF0;
    req_valid   = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL rmid_ready got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    repeat (35) @(negedge clk);
    #1;
    total++; if (uart_tx !== 1'b0) begin bad++; $display("[TB] FAIL rmid_bit3 got=%b exp=0", uart_tx); end
    req_valid = 2'b01;
    #1 reset  = 1'b1;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL rmid_tx got=%b exp=1", uart_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL rmid_ready_in_reset got=%b exp=00", req_ready); end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;
    busy_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_cnt++;
    end
    total++; if (busy_cnt !== 0) begin bad++; $display("[TB] FAIL rmid_retx busy_cycles=%0d exp=0", busy_cnt); end
    req_data[0] = 8'h81;
    req_valid   = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL rmid_ready2 got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    capture_frame(-1, got, ok, bl, rc);
    total++; if (got !== 8'h81) begin bad++; $display("[TB] FAIL rmid_byte got=%h exp=81", got); end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rmid_shape got=%b exp=1", ok); end
    total++; if (bl !== 0) begin bad++; $display("[TB] FAIL rmid_busy_frame low_cycles=%0d exp=0", bl); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("[TB] FAIL rmid_grant got=%b exp=0", grant_id); end
  endtask

  // Scenario sequence; each task leaves the line idle for the next one.
  initial begin
    test_reset();
    test_tie();
    test_single();
    test_req1_repeat();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
